// File: rtl/if_fetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and instruction memory (slave).
//
// Handshake: single outstanding request. The master raises ibus_req_o with ibus_addr_o
// and holds both unchanged until it samples ibus_ack_i=1 on a clock edge. That edge
// completes the transfer, and ibus_rdata_i is valid in the same cycle. An ack seen
// while ibus_req_o=0 means nothing. A request is never withdrawn before its ack.
//
// Signals:
//   ibus_req_o    master -> slave  fetch request
//   ibus_addr_o   master -> slave  fetch address (32)
//   ibus_ack_i    slave  -> master fetch complete
//   ibus_rdata_i  slave  -> master instruction word (32)
interface if_fetch_ctrl_if;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i;
   logic [31:0] ibus_rdata_i;

   modport master (output ibus_req_o, ibus_addr_o, input ibus_ack_i, ibus_rdata_i);
   modport slave  (input ibus_req_o, ibus_addr_o, output ibus_ack_i, ibus_rdata_i);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer. It owns the fetch PC and issues one request at a time on
// the instruction bus. A taken branch redirects after the delay slot, and a flush
// redirects at once. The fetched word and its PC go to the IF/ID stage.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_i[5:0]      [0] no new fetch, [1] hold IF/ID outputs (other bits unused here)
//   flush_i/new_pc_i  exception flush and its target
//   branch_flag_i/branch_target_i  taken branch resolved in ID and its target
//   ibus              instruction bus (master side)
//   pc_o/inst_o/inst_valid_o  IF/ID outputs
//   stallreq_o        stall request while a fetch has not returned
//   state_dbg         current FSM state (IDLE=0, FETCH=1, HOLD=2, DISCARD=3)
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall_i,
   input  logic                  flush_i,
   input  logic [31:0]           new_pc_i,
   input  logic                  branch_flag_i,
   input  logic [31:0]           branch_target_i,
   if_fetch_ctrl_if.master       ibus,
   output logic [31:0]           pc_o,
   output logic [31:0]           inst_o,
   output logic                  inst_valid_o,
   output logic                  stallreq_o,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DISCARD = 2'd3} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc;
   logic        br_pend;
   logic [31:0] br_tgt;
   logic [31:0] hold_inst;
   logic [31:0] hold_pc;

   logic        ack_seen;
   logic        fetch_done;
   logic        br_taken;
   logic [31:0] br_dest;

   // Only the two low stall bits concern the fetch stage.
   logic        unused_stall;
   assign unused_stall = ^stall_i[5:2];

   assign ack_seen   = ibus.ibus_req_o & ibus.ibus_ack_i;
   // A completed fetch whose word is kept (not in DISCARD).
   assign fetch_done = (state == FETCH) & ack_seen;
   // A branch that arrives on the same edge as the ack already steers the next fetch.
   assign br_taken   = branch_flag_i | br_pend;
   assign br_dest    = branch_flag_i ? branch_target_i : br_tgt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         // A request that is still outstanding must be drained before fetching again.
         state_nxt = (ibus.ibus_req_o && !ibus.ibus_ack_i) ? DISCARD : FETCH;
      end else begin
         case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (ack_seen && stall_i[1]) state_nxt = HOLD;
            HOLD:    if (!stall_i[1]) state_nxt = FETCH;
            DISCARD: if (ack_seen) state_nxt = FETCH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      stallreq_o = (ibus.ibus_req_o & ~ibus.ibus_ack_i)
                 | (state == DISCARD)
                 | ((state == FETCH) & ~ibus.ibus_req_o & ~stall_i[0]);
      state_dbg  = state;
   end

   // Datapath: bus request, fetch PC, branch tracking, hold buffer, IF/ID outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ibus.ibus_req_o  <= 1'b0;
         ibus.ibus_addr_o <= RESET_PC;
         fetch_pc         <= RESET_PC;
         br_pend          <= 1'b0;
         br_tgt           <= 32'h0;
         hold_inst        <= 32'h0;
         hold_pc          <= 32'h0;
         pc_o             <= RESET_PC;
         inst_o           <= 32'h0;
         inst_valid_o     <= 1'b0;
      end else begin
         // The request drops on every ack, including a flushed or discarded one.
         // A new request never launches on the ack edge, so fetches are separated
         // by at least one idle bus cycle.
         if (ack_seen) begin
            ibus.ibus_req_o <= 1'b0;
         end else if (!flush_i && state == FETCH && !ibus.ibus_req_o && !stall_i[0]) begin
            ibus.ibus_req_o  <= 1'b1;
            ibus.ibus_addr_o <= fetch_pc;
         end

         if (flush_i) begin
            fetch_pc <= new_pc_i;
            br_pend  <= 1'b0;
         end else if (fetch_done) begin
            fetch_pc <= br_taken ? br_dest : fetch_pc + 32'd4;
            br_pend  <= 1'b0;
         end else if (branch_flag_i) begin
            br_pend <= 1'b1;
            br_tgt  <= branch_target_i;
         end

         if (flush_i) begin
            hold_inst <= 32'h0;
            hold_pc   <= 32'h0;
         end else if (fetch_done && stall_i[1]) begin
            hold_inst <= ibus.ibus_rdata_i;
            hold_pc   <= ibus.ibus_addr_o;
         end

         if (flush_i) begin
            inst_valid_o <= 1'b0;
         end else if (!stall_i[1]) begin
            if (fetch_done) begin
               inst_o       <= ibus.ibus_rdata_i;
               pc_o         <= ibus.ibus_addr_o;
               inst_valid_o <= 1'b1;
            end else if (state == HOLD) begin
               inst_o       <= hold_inst;
               pc_o         <= hold_pc;
               inst_valid_o <= 1'b1;
            end else begin
               inst_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule
